pc_stack: RTL and testbench
===========================

# pc_stack

Parametrised program-counter unit for the single-cycle core. It supports sequential advance, relative jumps, absolute jumps, subroutine call/return through an internal return-address stack (RAS), pipeline stall, and a terminal HALT state. It sits at the front of the fetch path and drives the instruction-memory address. The decoder supplies one encoded operation per cycle.

## Interface
- D, 10: program-counter and target width (bits).
- S, 4: RAS depth (entries); power of two, ≥2.
- START, 0: PC value loaded on reset (D bits).
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; clock clk.
- stall  input  1  hold all state this cycle (op ignored).
- op  input  3  pc_op_t operation for the current instruction.
- target  input  D  jump offset (REL/CALL_REL, two's complement) or address (ABS/CALL_ABS).
- prog_ctr  output  D  current instruction address.
- halted  output  1  high while in HALT state.
- depth  output  $clog2(S)+1  valid RAS entries.
- stk_ovf  output  1  sticky: a CALL was issued with RAS full.
- stk_unf  output  1  sticky: a RET was issued with RAS empty.

## Operation
- Two-state FSM, RUN and HALT. Reset enters RUN.
- Priority per edge: reset > HALT state (frozen) > stall > op.
- In RUN, with stall=0, op selects the next PC:
  - NEXT: prog_ctr+1.
  - REL: prog_ctr+target.
  - ABS: target.
  - CALL_REL: push prog_ctr+1, then prog_ctr+target.
  - CALL_ABS: push prog_ctr+1, then target.
  - RET: pop; PC gets the popped value.
  - HALT: enter the HALT state; PC holds.
- Codes 3'b111 and any unused codes behave as NEXT.
- Arithmetic is modulo 2^D and wraps silently: 2^D-1 followed by +1 gives 0, and REL wraps in both directions.
- RAS is a circular buffer with pointer and count.
  - CALL when full (depth==S): overwrite the oldest entry, depth stays S, set stk_ovf.
  - RET when empty: PC becomes prog_ctr+1, depth stays 0, set stk_unf.
- stk_ovf and stk_unf clear only on reset.
- HALT state: prog_ctr, RAS, and flags are frozen; stall and op are ignored. Only reset exits this state.
- Reset: prog_ctr=START, halted=0, depth=0, stk_ovf=0, stk_unf=0. RAS contents need no reset; they are unreadable while depth=0.

## Timing
- All outputs are registered. The op sampled at edge N determines prog_ctr after edge N. Jumps have zero bubble.
- halted rises on the edge that accepts HALT. prog_ctr still shows the HALT instruction's address at that point.
- Push and pop take effect on the same edge as the PC update. A CALL followed immediately by a RET returns correctly, with no forwarding hazard.
- stall=1 holds prog_ctr, depth, the FSM, and the flags unchanged for that edge.
- Reset asserted mid-call or mid-stall: the next edge forces reset values regardless of op or stall.

## Structure
- Package pc_pkg:
  - pc_op_t enum (3 bits): NEXT=0, REL=1, ABS=2, CALL_REL=3, CALL_ABS=4, RET=5, HALT=6.
  - pc_state_t enum: RUN, HALT.
- Sub-module ras: a parametrised (D, S) circular stack.
  - Inputs: push, pop, push_data.
  - Outputs: top, depth, full, empty.
  - Overwrite-on-full behaviour lives inside ras.
  - pc_stack owns the FSM, next-PC mux, and sticky flags.

## Test plan
- Reset then 3×NEXT → prog_ctr 0,1,2,3; depth 0; flags 0. With START=12, reset → prog_ctr 12.
- At PC=5, REL target=10'h3FE (−2) → 3. At PC=1023, NEXT → 0. ABS target=200 → 200.
- At PC=10, CALL_ABS 100 → PC 100, depth 1. Then NEXT → 101, RET → 11, depth 0. Nested CALL_REL ×2 then RET ×2 returns in LIFO order.
- S=4, five CALLs with pushed addresses a1..a5 → depth 4, stk_ovf=1. Four RETs yield a5,a4,a3,a2. A fifth RET → PC+1, stk_unf=1.
- Stall for 3 cycles with op=ABS 50 → PC and depth unchanged. Release stall → PC 50.
- HALT at PC=7 → halted=1, PC 7 held for 10 cycles under any op or stall. Reset → prog_ctr START, halted=0, flags 0.

Source files
------------

// File: rtl/pc_stack_pkg.sv
// Shared types for the program-counter unit: decoder operation codes and FSM states.
package pc_pkg;

  typedef enum logic [2:0] {
    NEXT     = 3'd0,
    REL      = 3'd1,
    ABS      = 3'd2,
    CALL_REL = 3'd3,
    CALL_ABS = 3'd4,
    RET      = 3'd5,
    HALT     = 3'd6
  } pc_op_t;

  // State literals carry an S_ prefix so they do not collide with the HALT operation.
  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } pc_state_t;

endpackage

// File: rtl/pc_stack_if.sv
// Decoder-to-PC-unit bundle: the decoder (master) drives operations, the PC unit (slave) reports state.
interface pc_stack_if #(
  parameter int D = 10,
  parameter int S = 4
);
  logic                 stall;
  logic [2:0]           op;
  logic [D-1:0]         target;
  logic [D-1:0]         prog_ctr;
  logic                 halted;
  logic [$clog2(S):0]   depth;
  logic                 stk_ovf;
  logic                 stk_unf;

  modport master (
    output stall, op, target,
    input  prog_ctr, halted, depth, stk_ovf, stk_unf
  );

  modport slave (
    input  stall, op, target,
    output prog_ctr, halted, depth, stk_ovf, stk_unf
  );
endinterface

// File: rtl/pc_stack_ras.sv
// Circular return-address stack; a push while full silently overwrites the oldest entry.
module ras #(
  parameter int D = 10,
  parameter int S = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [D-1:0]       push_data,
  output logic [D-1:0]       top,
  output logic [$clog2(S):0] depth,
  output logic               full,
  output logic               empty
);
  localparam int PW = $clog2(S);
  localparam logic [PW:0] FULL_CNT = S[PW:0];

  logic [D-1:0]  r_mem [S];
  logic [PW-1:0] r_ptr;
  logic [PW:0]   r_count;

  always_ff @(posedge clk) begin
    if (push) r_mem[r_ptr] <= push_data;
  end

  // r_ptr is the next write slot; once full it already points at the oldest entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (push) begin
      r_ptr <= r_ptr + PW'(1);
      if (!full) r_count <= r_count + (PW+1)'(1);
    end else if (pop && !empty) begin
      r_ptr   <= r_ptr - PW'(1);
      r_count <= r_count - (PW+1)'(1);
    end
  end

  assign top   = r_mem[r_ptr - PW'(1)];
  assign depth = r_count;
  assign full  = (r_count == FULL_CNT);
  assign empty = (r_count == '0);
endmodule

// File: rtl/pc_stack.sv
// Program-counter unit: next-PC selection, call/return via the RAS, stall and terminal HALT.
module pc_stack
  import pc_pkg::*;
#(
  parameter int D = 10,
  parameter int S = 4,
  parameter logic [D-1:0] START = '0
) (
  input  logic       clk,
  input  logic       reset,
  pc_stack_if.slave  bus
);
  logic [D-1:0]       r_pc;
  pc_state_t          r_state;
  logic               r_ovf;
  logic               r_unf;

  pc_op_t             w_op;
  logic               w_run;
  logic [D-1:0]       w_pc_inc;
  logic [D-1:0]       w_next_pc;
  logic [D-1:0]       w_top;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [$clog2(S):0] w_depth;

  assign w_op     = pc_op_t'(bus.op);
  assign w_run    = (r_state == S_RUN) && !bus.stall;
  assign w_pc_inc = r_pc + D'(1);

  // Push/pop are gated by w_run so a stalled or halted cycle leaves the RAS untouched.
  always_comb begin
    w_next_pc = w_pc_inc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    case (w_op)
      REL:      w_next_pc = r_pc + bus.target;
      ABS:      w_next_pc = bus.target;
      CALL_REL: begin
        w_next_pc = r_pc + bus.target;
        w_push    = w_run;
      end
      CALL_ABS: begin
        w_next_pc = bus.target;
        w_push    = w_run;
      end
      RET: begin
        w_next_pc = w_empty ? w_pc_inc : w_top;
        w_pop     = w_run && !w_empty;
      end
      HALT:     w_next_pc = r_pc;
      default:  w_next_pc = w_pc_inc;
    endcase
  end

  ras #(.D(D), .S(S)) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_inc),
    .top       (w_top),
    .depth     (w_depth),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= START;
      r_state <= S_RUN;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (w_run) begin
      r_pc <= w_next_pc;
      if (w_op == HALT)          r_state <= S_HALT;
      if (w_push && w_full)      r_ovf   <= 1'b1;
      if (w_op == RET && w_empty) r_unf  <= 1'b1;
    end
  end

  assign bus.prog_ctr = r_pc;
  assign bus.halted   = (r_state == S_HALT);
  assign bus.depth    = w_depth;
  assign bus.stk_ovf  = r_ovf;
  assign bus.stk_unf  = r_unf;
endmodule

// File: tb/tb_pc_stack.sv
// Randomised and directed bench for pc_stack against a queue-based behavioural model.
module tb_pc_stack;
  import pc_pkg::*;

  localparam int D     = 10;
  localparam int S     = 4;
  localparam int START = 0;
  localparam int MASK  = (1 << D) - 1;

  logic clk = 1'b0;
  logic reset;

  pc_stack_if #(.D(D), .S(S)) bus ();
  pc_stack_if #(.D(D), .S(S)) bus12 ();

  pc_stack #(.D(D), .S(S), .START(10'(START))) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pc_stack #(.D(D), .S(S), .START(10'd12)) dut12 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus12)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  int m_pc;
  int q[$];
  bit m_halt, m_ovf, m_unf;

  function automatic logic [15:0] exp_vec();
    return {10'(m_pc), m_halt, 3'(q.size()), m_ovf, m_unf};
  endfunction

  function automatic logic [15:0] got_vec();
    return {bus.prog_ctr, bus.halted, bus.depth, bus.stk_ovf, bus.stk_unf};
  endfunction

  // One clock: drive inputs at the falling edge, then advance the model after the rising edge.
  task automatic drive(input bit rst, input bit stl, input logic [2:0] o, input int tgt);
    @(negedge clk);
    reset     = rst;
    bus.stall = stl;
    bus.op    = o;
    bus.target = 10'(tgt);
    @(posedge clk);
    #1;
    if (rst) begin
      m_pc = START; m_halt = 0; m_ovf = 0; m_unf = 0;
      q.delete();
    end else if (!m_halt && !stl) begin
      case (o)
        3'd1: m_pc = (m_pc + tgt) & MASK;
        3'd2: m_pc = tgt & MASK;
        3'd3, 3'd4: begin
          if (q.size() == S) begin
            void'(q.pop_front());
            m_ovf = 1;
          end
          q.push_back((m_pc + 1) & MASK);
          m_pc = (o == 3'd3) ? ((m_pc + tgt) & MASK) : (tgt & MASK);
        end
        3'd5: begin
          if (q.size() > 0) m_pc = q.pop_back();
          else begin
            m_pc  = (m_pc + 1) & MASK;
            m_unf = 1;
          end
        end
        3'd6: m_halt = 1;
        default: m_pc = (m_pc + 1) & MASK;
      endcase
    end
  endtask

  task automatic test_reset();
    drive(1, 0, NEXT, 0);
    drive(1, 0, NEXT, 0);
    nvec++;
    if (got_vec() !== exp_vec()) begin
      nerr++; $display("FAIL reset_state: got %h want %h", got_vec(), exp_vec());
    end
    nvec++;
    if (bus.prog_ctr !== 10'd0 || bus.depth !== 3'd0 || bus.stk_ovf !== 1'b0 || bus.stk_unf !== 1'b0) begin
      nerr++; $display("FAIL reset_const: got pc %0d depth %0d want pc 0 depth 0", bus.prog_ctr, bus.depth);
    end
    nvec++;
    if (bus12.prog_ctr !== 10'd12) begin
      nerr++; $display("FAIL reset_start12: got %0d want 12", bus12.prog_ctr);
    end
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, NEXT, 0);
      nvec++;
      if (bus.prog_ctr !== 10'(i) || got_vec() !== exp_vec()) begin
        nerr++; $display("FAIL next_seq%0d: got %h want pc %0d vec %h", i, got_vec(), i, exp_vec());
      end
    end
  endtask

  task automatic test_jumps();
    drive(0, 0, ABS, 5);
    drive(0, 0, REL, 'h3FE);
    nvec++;
    if (bus.prog_ctr !== 10'd3) begin
      nerr++; $display("FAIL rel_back: got %0d want 3", bus.prog_ctr);
    end
    drive(0, 0, ABS, 1023);
    drive(0, 0, NEXT, 0);
    nvec++;
    if (bus.prog_ctr !== 10'd0) begin
      nerr++; $display("FAIL next_wrap: got %0d want 0", bus.prog_ctr);
    end
    drive(0, 0, ABS, 200);
    nvec++;
    if (bus.prog_ctr !== 10'd200) begin
      nerr++; $display("FAIL abs200: got %0d want 200", bus.prog_ctr);
    end
    drive(0, 0, ABS, 1020);
    drive(0, 0, REL, 10);
    nvec++;
    if (bus.prog_ctr !== 10'd6 || got_vec() !== exp_vec()) begin
      nerr++; $display("FAIL rel_fwd_wrap: got %0d want 6", bus.prog_ctr);
    end
    drive(0, 0, 3'b111, 77);
    nvec++;
    if (bus.prog_ctr !== 10'd7) begin
      nerr++; $display("FAIL op7_next: got %0d want 7", bus.prog_ctr);
    end
  endtask

  task automatic test_call_ret();
    int exp_pc[5] = '{100, 101, 11, 60, 50};
    drive(1, 0, NEXT, 0);
    drive(0, 0, ABS, 10);
    drive(0, 0, CALL_ABS, 100);
    nvec++;
    if (bus.prog_ctr !== 10'(exp_pc[0]) || bus.depth !== 3'd1) begin
      nerr++; $display("FAIL call_abs: got pc %0d depth %0d want 100 1", bus.prog_ctr, bus.depth);
    end
    drive(0, 0, NEXT, 0);
    nvec++;
    if (bus.prog_ctr !== 10'(exp_pc[1])) begin
      nerr++; $display("FAIL call_next: got %0d want 101", bus.prog_ctr);
    end
    drive(0, 0, RET, 0);
    nvec++;
    if (bus.prog_ctr !== 10'(exp_pc[2]) || bus.depth !== 3'd0) begin
      nerr++; $display("FAIL ret: got pc %0d depth %0d want 11 0", bus.prog_ctr, bus.depth);
    end
    drive(0, 0, ABS, 40);
    drive(0, 0, CALL_REL, 20);
    drive(0, 0, CALL_REL, 'h3F6);
    nvec++;
    if (bus.prog_ctr !== 10'(exp_pc[4]) || bus.depth !== 3'd2) begin
      nerr++; $display("FAIL nested_call: got pc %0d depth %0d want 50 2", bus.prog_ctr, bus.depth);
    end
    drive(0, 0, RET, 0);
    nvec++;
    if (bus.prog_ctr !== 10'd61) begin
      nerr++; $display("FAIL nested_ret1: got %0d want 61", bus.prog_ctr);
    end
    drive(0, 0, RET, 0);
    nvec++;
    if (bus.prog_ctr !== 10'd41 || got_vec() !== exp_vec()) begin
      nerr++; $display("FAIL nested_ret2: got %0d want 41", bus.prog_ctr);
    end
  endtask

  task automatic test_overflow();
    int exp_ret[4] = '{131, 121, 111, 101};
    drive(1, 0, NEXT, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, CALL_ABS, 100 + i * 10);
    nvec++;
    if (bus.depth !== 3'd4 || bus.stk_ovf !== 1'b1 || bus.prog_ctr !== 10'd140) begin
      nerr++; $display("FAIL ovf: got depth %0d ovf %0b pc %0d want 4 1 140", bus.depth, bus.stk_ovf, bus.prog_ctr);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, RET, 0);
      nvec++;
      if (bus.prog_ctr !== 10'(exp_ret[i]) || got_vec() !== exp_vec()) begin
        nerr++; $display("FAIL ovf_ret%0d: got %0d want %0d", i, bus.prog_ctr, exp_ret[i]);
      end
    end
    drive(0, 0, RET, 0);
    nvec++;
    if (bus.prog_ctr !== 10'd102 || bus.stk_unf !== 1'b1 || bus.depth !== 3'd0 || bus.stk_ovf !== 1'b1) begin
      nerr++; $display("FAIL unf: got pc %0d unf %0b depth %0d want 102 1 0", bus.prog_ctr, bus.stk_unf, bus.depth);
    end
  endtask

  task automatic test_stall();
    drive(1, 0, NEXT, 0);
    drive(0, 0, ABS, 20);
    drive(0, 0, CALL_ABS, 30);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, ABS, 50);
      nvec++;
      if (bus.prog_ctr !== 10'd30 || bus.depth !== 3'd1) begin
        nerr++; $display("FAIL stall%0d: got pc %0d depth %0d want 30 1", i, bus.prog_ctr, bus.depth);
      end
    end
    drive(0, 1, RET, 0);
    nvec++;
    if (bus.prog_ctr !== 10'd30 || bus.depth !== 3'd1 || bus.stk_unf !== 1'b0) begin
      nerr++; $display("FAIL stall_ret: got pc %0d depth %0d want 30 1", bus.prog_ctr, bus.depth);
    end
    drive(0, 0, ABS, 50);
    nvec++;
    if (bus.prog_ctr !== 10'd50) begin
      nerr++; $display("FAIL stall_release: got %0d want 50", bus.prog_ctr);
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 0, NEXT, 0);
    drive(0, 0, ABS, 500);
    drive(0, 0, CALL_ABS, 300);
    drive(0, 0, RET, 0);
    nvec++;
    if (bus.prog_ctr !== 10'd501 || bus.depth !== 3'd0) begin
      nerr++; $display("FAIL call_ret_b2b: got pc %0d depth %0d want 501 0", bus.prog_ctr, bus.depth);
    end
    drive(0, 0, CALL_REL, 4);
    drive(1, 1, CALL_ABS, 5);
    nvec++;
    if (bus.prog_ctr !== 10'd0 || bus.depth !== 3'd0 || got_vec() !== exp_vec()) begin
      nerr++; $display("FAIL reset_mid_stall: got pc %0d depth %0d want 0 0", bus.prog_ctr, bus.depth);
    end
  endtask

  task automatic test_halt();
    drive(1, 0, NEXT, 0);
    drive(0, 0, CALL_ABS, 7);
    drive(0, 0, HALT, 0);
    nvec++;
    if (bus.halted !== 1'b1 || bus.prog_ctr !== 10'd7 || bus.depth !== 3'd1) begin
      nerr++; $display("FAIL halt_enter: got halted %0b pc %0d want 1 7", bus.halted, bus.prog_ctr);
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, $urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom);
      nvec++;
      if (bus.halted !== 1'b1 || bus.prog_ctr !== 10'd7 || bus.depth !== 3'd1 || bus.stk_unf !== 1'b0) begin
        nerr++; $display("FAIL halt_hold%0d: got halted %0b pc %0d depth %0d want 1 7 1", i, bus.halted, bus.prog_ctr, bus.depth);
      end
    end
    drive(1, 0, NEXT, 0);
    nvec++;
    if (bus.halted !== 1'b0 || bus.prog_ctr !== 10'(START) || bus.stk_ovf !== 1'b0 || bus.depth !== 3'd0) begin
      nerr++; $display("FAIL halt_reset: got halted %0b pc %0d want 0 %0d", bus.halted, bus.prog_ctr, START);
    end
  endtask

  task automatic test_random();
    logic [2:0] o;
    bit rst, stl;
    drive(1, 0, NEXT, 0);
    for (int i = 0; i < 400; i++) begin
      o = 3'($urandom_range(0, 7));
      if (o == 3'd6 && $urandom_range(0, 9) != 0) o = 3'd0;
      rst = m_halt ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 49) == 0);
      stl = ($urandom_range(0, 4) == 0);
      drive(rst, stl, o, $urandom);
      nvec++;
      if (got_vec() !== exp_vec()) begin
        nerr++; $display("FAIL random%0d: got %h want %h (op %0d)", i, got_vec(), exp_vec(), o);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.stall   = 1'b0;
    bus.op      = 3'd0;
    bus.target  = '0;
    bus12.stall = 1'b1;
    bus12.op    = 3'd0;
    bus12.target = '0;
    m_pc = START;
    test_reset();
    test_jumps();
    test_call_ret();
    test_overflow();
    test_stall();
    test_back_to_back();
    test_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
